// File: rtl/ccd_gate_pkg.sv
// ccd_gate_pkg: shared FSM state, capture mode and pending-command encodings for the CCD frame gate
// No ports; imported by ccd_frame_gate.
package ccd_gate_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, FRAME, DONE} state_t;
    localparam logic MODE_CONT   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;
    // Numeric order equals command priority, so a plain compare picks the winner.
    typedef enum logic [1:0] {CMD_NONE, CMD_RUN, CMD_CAPTURE, CMD_STOP} cmd_t;
    function automatic cmd_t cmdOf(input logic stop, input logic capture, input logic run);
        return stop ? CMD_STOP : capture ? CMD_CAPTURE : run ? CMD_RUN : CMD_NONE;
    endfunction
endpackage

// File: rtl/ccd_sync_edge.sv
// ccd_sync_edge: two-stage register of sensor FVAL/LVAL/data with edge detection
// Ports: clk, reset (sync, active-high); iFVAL/iLVAL/iDATA raw sensor inputs;
//        fvalQ/lvalQ/dataQ first-stage registers; fvalRise/fvalFall/lvalFall edge strobes.
module ccd_sync_edge #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iFVAL,
    input  logic              iLVAL,
    input  logic [DATA_W-1:0] iDATA,
    output logic              fvalQ,
    output logic              lvalQ,
    output logic [DATA_W-1:0] dataQ,
    output logic              fvalRise,
    output logic              fvalFall,
    output logic              lvalFall
);
    logic fvalQ2, lvalQ2;
    // FVAL stages reset high so a frame already running at reset release shows no rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            fvalQ  <= 1'b1;
            fvalQ2 <= 1'b1;
            lvalQ  <= 1'b0;
            lvalQ2 <= 1'b0;
            dataQ  <= '0;
        end else begin
            fvalQ  <= iFVAL;
            fvalQ2 <= fvalQ;
            lvalQ  <= iLVAL;
            lvalQ2 <= lvalQ;
            dataQ  <= iDATA;
        end
    end
    assign fvalRise = fvalQ & ~fvalQ2;
    assign fvalFall = ~fvalQ & fvalQ2;
    assign lvalFall = ~lvalQ & lvalQ2;
endmodule

// File: rtl/ccd_frame_gate.sv
// ccd_frame_gate: admits whole CCD frames in continuous or single-capture mode
// Ports: clk, reset (sync, active-high); do_run/do_capture/do_stop command pulses;
//        iFVAL/iLVAL/iDATA sensor stream; oDVAL/oDATA gated pixels with oX_Cont/oY_Cont
//        coordinates; oFrame_Cont admitted frame count; busy (ARMED or FRAME);
//        capture_done level after a single capture.
module ccd_frame_gate
    import ccd_gate_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int X_W    = 12,
    parameter int Y_W    = 12,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              do_run,
    input  logic              do_capture,
    input  logic              do_stop,
    input  logic              iFVAL,
    input  logic              iLVAL,
    input  logic [DATA_W-1:0] iDATA,
    output logic              oDVAL,
    output logic [DATA_W-1:0] oDATA,
    output logic [X_W-1:0]    oX_Cont,
    output logic [Y_W-1:0]    oY_Cont,
    output logic [FCNT_W-1:0] oFrame_Cont,
    output logic              busy,
    output logic              capture_done
);
    logic fvalQ, lvalQ, fvalRise, fvalFall, lvalFall, gate, mode;
    logic [DATA_W-1:0] dataQ;
    state_t state;
    cmd_t pending, cmdIn, cmdEnd;
    ccd_sync_edge #(.DATA_W(DATA_W)) uSync (
        .clk(clk), .reset(reset), .iFVAL(iFVAL), .iLVAL(iLVAL), .iDATA(iDATA),
        .fvalQ(fvalQ), .lvalQ(lvalQ), .dataQ(dataQ),
        .fvalRise(fvalRise), .fvalFall(fvalFall), .lvalFall(lvalFall)
    );
    assign cmdIn  = cmdOf(do_stop, do_capture, do_run);
    // A pulse arriving on the frame-end cycle itself still counts as pending.
    assign cmdEnd = (cmdIn > pending) ? cmdIn : pending;
    assign gate   = (state == FRAME) || (state == ARMED && fvalRise);
    assign busy   = (state == ARMED) || (state == FRAME);
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mode         <= MODE_CONT;
            pending      <= CMD_NONE;
            capture_done <= 1'b0;
            oDVAL        <= 1'b0;
            oDATA        <= '0;
            oX_Cont      <= '0;
            oY_Cont      <= '0;
            oFrame_Cont  <= '0;
        end else begin
            oDVAL <= gate & fvalQ & lvalQ;
            oDATA <= dataQ;
            if (state == ARMED && fvalRise) begin
                oX_Cont <= '0;
                oY_Cont <= '0;
            end else begin
                oX_Cont <= lvalFall ? '0 : oDVAL ? oX_Cont + 1'b1 : oX_Cont;
                oY_Cont <= (lvalFall && gate) ? oY_Cont + 1'b1 : oY_Cont;
            end
            case (state)
                IDLE, DONE: begin
                    if (cmdIn == CMD_CAPTURE || cmdIn == CMD_RUN) begin
                        state        <= ARMED;
                        mode         <= (cmdIn == CMD_CAPTURE) ? MODE_SINGLE : MODE_CONT;
                        capture_done <= 1'b0;
                    end
                end
                ARMED: begin
                    // Frame start wins; a stop on that same cycle ends the frame it opened.
                    if (fvalRise) begin
                        state   <= FRAME;
                        pending <= (cmdIn == CMD_STOP) ? CMD_STOP : CMD_NONE;
                        if (cmdIn == CMD_CAPTURE || cmdIn == CMD_RUN)
                            mode <= (cmdIn == CMD_CAPTURE) ? MODE_SINGLE : MODE_CONT;
                    end else if (cmdIn == CMD_STOP) begin
                        state <= IDLE;
                    end else if (cmdIn != CMD_NONE) begin
                        mode <= (cmdIn == CMD_CAPTURE) ? MODE_SINGLE : MODE_CONT;
                    end
                end
                FRAME: begin
                    if (fvalFall) begin
                        pending      <= CMD_NONE;
                        oFrame_Cont  <= oFrame_Cont + 1'b1;
                        state        <= (cmdEnd == CMD_STOP) ? IDLE :
                                        (cmdEnd != CMD_NONE || mode == MODE_CONT) ? ARMED : DONE;
                        capture_done <= (cmdEnd == CMD_NONE) && (mode == MODE_SINGLE);
                        if (cmdEnd == CMD_CAPTURE || cmdEnd == CMD_RUN)
                            mode <= (cmdEnd == CMD_CAPTURE) ? MODE_SINGLE : MODE_CONT;
                    end else begin
                        pending <= cmdEnd;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
